// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver that deframes and checks 11-bit frames and folds the E0/F0 prefixes into key events
module ps2_kbd_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_strobe,
  output logic       err_strobe
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t r_state, w_state;
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_f, r_clk_fd;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic [7:0] r_shift, w_shift, w_rx_byte, w_key_code;
  logic [2:0] r_cnt, w_cnt;
  logic r_par, w_par, r_par_ok, w_par_ok, r_ext, w_ext, r_rel, w_rel;
  logic w_rx_strobe, w_key_strobe, w_key_ext, w_key_release, w_err, w_fall;
  assign w_fall = r_clk_fd & ~r_clk_f;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_f, r_clk_fd} <= '1;
      r_fcnt <= '0;
    end else begin
      {r_clk_s2, r_clk_s1} <= {r_clk_s1, ps2_kbd_clk};
      {r_dat_s2, r_dat_s1} <= {r_dat_s1, ps2_kbd_data};
      r_clk_fd <= r_clk_f;
      // the filtered level flips on the FILTER_LEN-th consecutive differing sample
      if (r_clk_s2 == r_clk_f) r_fcnt <= '0;
      else if (r_fcnt == FMAX) begin
        r_clk_f <= r_clk_s2;
        r_fcnt  <= '0;
      end else r_fcnt <= r_fcnt + 1'b1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt <= '0;
      r_par <= 1'b0;
      r_par_ok <= 1'b0;
      r_tcnt <= '0;
      r_ext <= 1'b0;
      r_rel <= 1'b0;
      rx_byte <= '0;
      rx_strobe <= 1'b0;
      key_code <= '0;
      key_ext <= 1'b0;
      key_release <= 1'b0;
      key_strobe <= 1'b0;
      err_strobe <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_cnt <= w_cnt;
      r_par <= w_par;
      r_par_ok <= w_par_ok;
      r_tcnt <= w_tcnt;
      r_ext <= w_ext;
      r_rel <= w_rel;
      rx_byte <= w_rx_byte;
      rx_strobe <= w_rx_strobe;
      key_code <= w_key_code;
      key_ext <= w_key_ext;
      key_release <= w_key_release;
      key_strobe <= w_key_strobe;
      err_strobe <= w_err;
    end
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_cnt = r_cnt;
    w_par = r_par;
    w_par_ok = r_par_ok;
    w_tcnt = r_state == IDLE ? '0 : r_tcnt == TMAX ? r_tcnt : r_tcnt + 1'b1;
    w_ext = r_ext;
    w_rel = r_rel;
    w_rx_byte = rx_byte;
    w_rx_strobe = 1'b0;
    w_key_code = key_code;
    w_key_ext = key_ext;
    w_key_release = key_release;
    w_key_strobe = 1'b0;
    w_err = 1'b0;
    if (w_fall) begin
      w_tcnt = '0;
      case (r_state)
        IDLE: if (!r_dat_s2) begin
          w_state = DATA;
          w_cnt = '0;
          w_par = 1'b1;
          w_shift = '0;
        end
        DATA: begin
          w_shift = {r_dat_s2, r_shift[7:1]};
          w_par = r_par ^ r_dat_s2;
          w_cnt = r_cnt + 1'b1;
          w_state = r_cnt == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          w_par_ok = r_dat_s2 == r_par;
          w_state = STOP;
        end
        default: begin
          w_state = IDLE;
          if (r_par_ok && r_dat_s2) begin
            w_rx_byte = r_shift;
            w_rx_strobe = 1'b1;
            if (r_shift == 8'hE0) w_ext = 1'b1;
            else if (r_shift == 8'hF0) w_rel = 1'b1;
            else begin
              w_key_code = r_shift;
              w_key_ext = r_ext;
              w_key_release = r_rel;
              w_key_strobe = 1'b1;
              w_ext = 1'b0;
              w_rel = 1'b0;
            end
          end else begin
            w_err = 1'b1;
            w_ext = 1'b0;
            w_rel = 1'b0;
          end
        end
      endcase
    end else if (r_state != IDLE && r_tcnt == TMAX) begin
      w_state = IDLE;
      w_tcnt = '0;
      w_err = 1'b1;
      w_ext = 1'b0;
      w_rel = 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed frames against ps2_kbd_rx with strobe counters and hand-computed expectations
module tb_ps2_kbd_rx;
  localparam int TO = 300;
  localparam int FL = 4;
  localparam int H = 20;
  logic clk = 1'b0, reset_n = 1'b0, ps_clk = 1'b1, ps_dat = 1'b1;
  logic [7:0] rx_byte, key_code;
  logic rx_strobe, key_ext, key_release, key_strobe, err_strobe;
  int checks = 0, errors = 0;
  int n_rx = 0, n_key = 0, n_err = 0, n_bad = 0;
  int b_rx, b_key, b_err;
  logic p_rx = 1'b0, p_key = 1'b0, p_err = 1'b0;
  ps2_kbd_rx #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_kbd_clk(ps_clk), .ps2_kbd_data(ps_dat),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_strobe(key_strobe), .err_strobe(err_strobe)
  );
  always #5 clk = ~clk;
  // strobes are sampled mid-cycle; widths > 1 and illegal coincidences are tallied in n_bad
  always @(negedge clk) begin
    n_rx += int'(rx_strobe);
    n_key += int'(key_strobe);
    n_err += int'(err_strobe);
    if ((rx_strobe && p_rx) || (key_strobe && p_key) || (err_strobe && p_err) ||
        (err_strobe && rx_strobe) || (key_strobe && !rx_strobe)) n_bad++;
    p_rx = rx_strobe;
    p_key = key_strobe;
    p_err = err_strobe;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [10:0] frm(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, ~^d ^ pflip, d, 1'b0};
  endfunction
  task automatic send(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps_dat = f[i];
      repeat (H) @(negedge clk);
      ps_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    ps_dat = 1'b1;
    repeat (H) @(negedge clk);
  endtask
  task automatic snap();
    b_rx = n_rx;
    b_key = n_key;
    b_err = n_err;
  endtask
  task automatic deltas(input string tag, input int erx, input int ekey, input int eerr);
    chk({tag, "_rx_cnt"}, n_rx - b_rx, erx);
    chk({tag, "_key_cnt"}, n_key - b_key, ekey);
    chk({tag, "_err_cnt"}, n_err - b_err, eerr);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_flags", {key_ext, key_release}, 2'b00);
    chk("rst_strobes", {rx_strobe, key_strobe, err_strobe}, 3'b000);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    send(frm(8'h1C, 1'b0, 1'b1), 11);
    deltas("make", 1, 1, 0);
    chk("make_rx_byte", rx_byte, 8'h1C);
    chk("make_key", {key_code, key_ext, key_release}, {8'h1C, 2'b00});
    snap();
    send(frm(8'hE0, 1'b0, 1'b1), 11);
    send(frm(8'hF0, 1'b0, 1'b1), 11);
    deltas("prefix", 2, 0, 0);
    chk("prefix_rx_byte", rx_byte, 8'hF0);
    snap();
    send(frm(8'h75, 1'b0, 1'b1), 11);
    deltas("extrel", 1, 1, 0);
    chk("extrel_key", {key_code, key_ext, key_release}, {8'h75, 2'b11});
    snap();
    send(frm(8'h75, 1'b0, 1'b1), 11);
    deltas("plain75", 1, 1, 0);
    chk("plain75_key", {key_code, key_ext, key_release}, {8'h75, 2'b00});
    snap();
    send(frm(8'hF0, 1'b0, 1'b1), 11);
    send(frm(8'hE0, 1'b0, 1'b1), 11);
    send(frm(8'hE0, 1'b0, 1'b1), 11);
    send(frm(8'h6B, 1'b0, 1'b1), 11);
    deltas("relext", 4, 1, 0);
    chk("relext_key", {key_code, key_ext, key_release}, {8'h6B, 2'b11});
    snap();
    send(frm(8'h1C, 1'b1, 1'b1), 11);
    deltas("parerr", 0, 0, 1);
    chk("parerr_rx_byte", rx_byte, 8'h6B);
    snap();
    send(frm(8'hE0, 1'b0, 1'b1), 11);
    send(frm(8'h1C, 1'b1, 1'b1), 11);
    send(frm(8'h1C, 1'b0, 1'b1), 11);
    deltas("cancel", 2, 1, 1);
    chk("cancel_key", {key_code, key_ext, key_release}, {8'h1C, 2'b00});
    snap();
    send(frm(8'h29, 1'b0, 1'b0), 11);
    deltas("stoperr", 0, 0, 1);
    chk("stoperr_rx_byte", rx_byte, 8'h1C);
    snap();
    send(frm(8'h29, 1'b0, 1'b1), 11);
    deltas("after_stop", 1, 1, 0);
    chk("after_stop_key", {rx_byte, key_code}, {8'h29, 8'h29});
    snap();
    send(frm(8'h5A, 1'b0, 1'b1), 5);
    repeat (TO + 50) @(negedge clk);
    deltas("timeout", 0, 0, 1);
    snap();
    send(frm(8'h1C, 1'b0, 1'b1), 11);
    deltas("after_to", 1, 1, 0);
    chk("after_to_key", {rx_byte, key_code, key_ext, key_release}, {8'h1C, 8'h1C, 2'b00});
    snap();
    ps_dat = 1'b0;
    ps_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps_clk = 1'b1;
    repeat (5) @(negedge clk);
    ps_dat = 1'b1;
    repeat (TO + 50) @(negedge clk);
    deltas("glitch", 0, 0, 0);
    snap();
    send(frm(8'h33, 1'b0, 1'b1), 4);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_rx_byte", rx_byte, 8'h00);
    chk("async_rst_key", {key_code, key_ext, key_release}, 10'h000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (TO + 50) @(negedge clk);
    deltas("post_rst", 0, 0, 0);
    snap();
    send(frm(8'h5A, 1'b0, 1'b1), 11);
    deltas("final", 1, 1, 0);
    chk("final_key", {rx_byte, key_code}, {8'h5A, 8'h5A});
    chk("strobe_rules", n_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
